// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: receive-side VGA timing checker.
// Recovers the pixel position from HSYNC/VSYNC edges, measures line and frame length,
// declares lock against the expected totals, counts timing errors and captures the
// RGB value at a probe coordinate.
module vga_sync_monitor #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_TOTAL     = 521,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iPixelEn,
    input  logic       iHsync,
    input  logic       iVsync,
    input  logic [2:0] iRGB,
    input  logic [9:0] iProbeX,
    input  logic [9:0] iProbeY,
    output logic [9:0] oHcount,
    output logic [9:0] oVcount,
    output logic [9:0] oLineLen,
    output logic [9:0] oFrameLines,
    output logic       oLocked,
    output logic       oFrameTick,
    output logic [2:0] oProbeRGB,
    output logic       oProbeValid,
    output logic [7:0] oErrCount
);

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } state_t;

    state_t     state, stateNext;
    logic       checkOk, checkOkNext;
    logic       errInc;
    logic       hsPrev, vsPrev, vPending;
    logic       hAssert, vAssert, reload;
    logic       hSatHit, lineBad, frameBad, mismatch;
    logic [9:0] hcPlus1, vcPlus1;

    assign hcPlus1  = oHcount + 10'd1;
    assign vcPlus1  = oVcount + 10'd1;

    assign hAssert  = iPixelEn && (iHsync == SYNC_ACTIVE) && (hsPrev != SYNC_ACTIVE);
    assign vAssert  = iPixelEn && (iVsync == SYNC_ACTIVE) && (vsPrev != SYNC_ACTIVE);
    // A vsync edge arms the row reload; it takes effect on the next hsync edge,
    // or on the same sample when both syncs assert together.
    assign reload   = hAssert && (vPending || vAssert);

    // Flag only the step into saturation so a stuck hsync is counted once.
    assign hSatHit  = iPixelEn && !hAssert && (oHcount == 10'd1022);
    assign lineBad  = hAssert && (hcPlus1 != 10'(H_TOTAL));
    assign frameBad = reload && (vcPlus1 != 10'(V_TOTAL));
    assign mismatch = lineBad || frameBad || hSatHit;

    assign oLocked  = (state == LOCKED);

    // Sync edge sampling, position recovery and line/frame length measurement.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hsPrev      <= ~SYNC_ACTIVE;
            vsPrev      <= ~SYNC_ACTIVE;
            vPending    <= 1'b0;
            oHcount     <= '0;
            oVcount     <= '0;
            oLineLen    <= '0;
            oFrameLines <= '0;
            oFrameTick  <= 1'b0;
        end else begin
            oFrameTick <= 1'b0;
            if (iPixelEn) begin
                hsPrev <= iHsync;
                vsPrev <= iVsync;
                if (hAssert) begin
                    oHcount  <= '0;
                    oLineLen <= hcPlus1;
                end else if (oHcount != '1) begin
                    oHcount <= hcPlus1;
                end
                if (reload) begin
                    oVcount     <= '0;
                    oFrameLines <= vcPlus1;
                    vPending    <= 1'b0;
                    oFrameTick  <= 1'b1;
                end else begin
                    if (hAssert && (oVcount != '1)) begin
                        oVcount <= vcPlus1;
                    end
                    if (vAssert) begin
                        vPending <= 1'b1;
                    end
                end
            end
        end
    end

    // Lock FSM state register and per-frame check flag.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= SEARCH;
            checkOk <= 1'b0;
        end else begin
            state   <= stateNext;
            checkOk <= checkOkNext;
        end
    end

    // Lock FSM next state: one fully clean frame between reloads is needed to lock.
    always_comb begin
        stateNext   = state;
        checkOkNext = checkOk;
        errInc      = 1'b0;
        case (state)
            SEARCH: begin
                if (reload) begin
                    stateNext   = MEASURE;
                    checkOkNext = 1'b1;
                end
            end
            MEASURE: begin
                if (reload) begin
                    if (checkOk && !mismatch) begin
                        stateNext = LOCKED;
                    end
                    checkOkNext = 1'b1;
                end else if (mismatch) begin
                    checkOkNext = 1'b0;
                end
            end
            LOCKED: begin
                if (mismatch) begin
                    errInc    = 1'b1;
                    stateNext = SEARCH;
                end
            end
            default: begin
                stateNext = SEARCH;
            end
        endcase
    end

    // Saturating timing-error counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oErrCount <= '0;
        end else if (errInc && (oErrCount != '1)) begin
            oErrCount <= oErrCount + 8'd1;
        end
    end

    // Probe pixel capture while locked.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oProbeRGB   <= '0;
            oProbeValid <= 1'b0;
        end else begin
            oProbeValid <= 1'b0;
            if ((state == LOCKED) && iPixelEn && (oHcount == iProbeX) && (oVcount == iProbeY)) begin
                oProbeRGB   <= iRGB;
                oProbeValid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: scoreboard bench for vga_sync_monitor on a reduced 12x5 raster.
module tb_vga_sync_monitor;

    localparam int H   = 12;
    localparam int V   = 5;
    localparam int HSW = 2;
    localparam int VSL = 2;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       iPixelEn;
    logic       iHsync;
    logic       iVsync;
    logic [2:0] iRGB;
    logic [9:0] iProbeX;
    logic [9:0] iProbeY;
    logic [9:0] oHcount;
    logic [9:0] oVcount;
    logic [9:0] oLineLen;
    logic [9:0] oFrameLines;
    logic       oLocked;
    logic       oFrameTick;
    logic [2:0] oProbeRGB;
    logic       oProbeValid;
    logic [7:0] oErrCount;

    vga_sync_monitor #(
        .H_TOTAL    (H),
        .V_TOTAL    (V),
        .SYNC_ACTIVE(1'b0)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .iPixelEn   (iPixelEn),
        .iHsync     (iHsync),
        .iVsync     (iVsync),
        .iRGB       (iRGB),
        .iProbeX    (iProbeX),
        .iProbeY    (iProbeY),
        .oHcount    (oHcount),
        .oVcount    (oVcount),
        .oLineLen   (oLineLen),
        .oFrameLines(oFrameLines),
        .oLocked    (oLocked),
        .oFrameTick (oFrameTick),
        .oProbeRGB  (oProbeRGB),
        .oProbeValid(oProbeValid),
        .oErrCount  (oErrCount)
    );

    always #5 Clock = ~Clock;

    int         nChecks = 0;
    int         nFails  = 0;
    int         gap     = 1;
    bit         armed   = 1'b0;
    logic [19:0] frameQ[$];
    logic [2:0]  probeQ[$];

    logic mPrevH, mPrevV, mPend;
    int   vModel, pixSince;

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mPrevH   = 1'b1;
        mPrevV   = 1'b1;
        mPend    = 1'b0;
        vModel   = 0;
        pixSince = 0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_hcount"}, oHcount, 0);
        check({tag, "_vcount"}, oVcount, 0);
        check({tag, "_linelen"}, oLineLen, 0);
        check({tag, "_framelines"}, oFrameLines, 0);
        check({tag, "_locked"}, oLocked, 0);
        check({tag, "_frametick"}, oFrameTick, 0);
        check({tag, "_probergb"}, oProbeRGB, 0);
        check({tag, "_probevalid"}, oProbeValid, 0);
        check({tag, "_errcount"}, oErrCount, 0);
    endtask

    task automatic gapWait();
        repeat (gap) begin
            @(posedge Clock);
            #1;
        end
    endtask

    // One pixel-enable sample; the expected frame-tick payload is queued here.
    task automatic pix(input logic hs, input logic vs, input logic [2:0] rgb);
        logic hA, vA;
        hA = (hs == 1'b0) && (mPrevH != 1'b0);
        vA = (vs == 1'b0) && (mPrevV != 1'b0);
        if (hA) begin
            if (mPend || vA) begin
                frameQ.push_back({10'(vModel + 1), 10'(pixSince + 1)});
                vModel = 0;
                mPend  = 1'b0;
            end else if (vModel < 1023) begin
                vModel++;
            end
            pixSince = 0;
        end else begin
            if (vA) mPend = 1'b1;
            if (pixSince < 1023) pixSince++;
        end
        mPrevH   = hs;
        mPrevV   = vs;
        iHsync   = hs;
        iVsync   = vs;
        iRGB     = rgb;
        iPixelEn = 1'b1;
        @(posedge Clock);
        #1;
        iPixelEn = 1'b0;
        iRGB     = 3'b000;
    endtask

    task automatic frame(input int firstLine, input int lastLine, input int shortLine, input int expErr);
        for (int ln = firstLine; ln <= lastLine; ln++) begin
            int len;
            len = (ln == shortLine) ? H - 1 : H;
            for (int p = 0; p < len; p++) begin
                logic [2:0] rgb;
                logic       endsShort;
                endsShort = (shortLine >= 0) && (ln == shortLine + 1) && (p == 0);
                rgb = 3'b000;
                if (armed) begin
                    rgb = (ln == 3 && p == 8) ? 3'b101 : 3'b010;
                    if (ln == 3 && p == 8) probeQ.push_back(3'b101);
                end
                if (endsShort) check("locked_before_short_line", oLocked, 1);
                pix(p >= HSW, ln >= VSL, rgb);
                if (endsShort) begin
                    check("errcount_after_short_line", oErrCount, expErr);
                    check("unlocked_after_short_line", oLocked, 0);
                end
                gapWait();
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a frame tick or probe capture.
    always @(negedge Clock) begin : monitor
        logic [19:0] fe;
        logic [2:0]  pe;
        if (oFrameTick) begin
            if (frameQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL frame_tick_unexpected: got pulse, expected none");
            end else begin
                fe = frameQ.pop_front();
                check("frame_lines", oFrameLines, fe[19:10]);
                check("line_len", oLineLen, fe[9:0]);
            end
        end
        if (oProbeValid) begin
            if (probeQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL probe_unexpected: got rgb %0d, expected no capture", oProbeRGB);
            end else begin
                pe = probeQ.pop_front();
                check("probe_rgb", oProbeRGB, pe);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        Reset    = 1'b1;
        iPixelEn = 1'b0;
        iHsync   = 1'b1;
        iVsync   = 1'b1;
        iRGB     = 3'b000;
        iProbeX  = 10'd1000;
        iProbeY  = 10'd1000;
        modelReset();
        repeat (3) @(posedge Clock);
        #1;
        checkAllZero("reset");
        Reset = 1'b0;

        // Initial lock: first reload, then one clean frame.
        frame(0, V - 1, -1, 0);
        check("not_locked_after_first_frame", oLocked, 0);
        frame(0, V - 1, -1, 0);
        check("locked_after_clean_frame", oLocked, 1);
        check("linelen_nominal", oLineLen, H);
        check("framelines_nominal", oFrameLines, V);
        check("errcount_nominal", oErrCount, 0);

        // One short line while locked, then relock.
        frame(0, V - 1, 2, 1);
        frame(0, V - 1, -1, 0);
        check("still_measuring", oLocked, 0);
        frame(0, V - 1, -1, 0);
        check("relocked_after_short", oLocked, 1);

        // Hsync stuck inactive.
        for (int i = 0; i < 1100; i++) begin
            pix(1'b1, 1'b1, 3'b000);
            gapWait();
        end
        check("hcount_saturated", oHcount, 1023);
        check("errcount_after_stuck", oErrCount, 2);
        check("unlocked_after_stuck", oLocked, 0);
        frame(0, V - 1, -1, 0);
        check("measuring_after_stuck", oLocked, 0);
        frame(0, V - 1, -1, 0);
        check("relocked_after_stuck", oLocked, 1);

        // Probe at column 7, row 3 over two locked frames.
        iProbeX = 10'd7;
        iProbeY = 10'd3;
        armed   = 1'b1;
        frame(0, V - 1, -1, 0);
        frame(0, V - 1, -1, 0);
        armed   = 1'b0;
        iProbeX = 10'd1000;
        iProbeY = 10'd1000;
        repeat (2) @(posedge Clock);
        #1;
        check("probe_all_captured", probeQ.size(), 0);
        check("probe_rgb_held", oProbeRGB, 3'b101);

        // Error counter saturation: alternate a short-line frame with a clean frame.
        gap = 0;
        for (int i = 0; i < 300; i++) begin
            frame(0, V - 1, 2, (3 + i > 255) ? 255 : 3 + i);
            frame(0, V - 1, -1, 0);
        end
        gap = 1;
        check("errcount_saturated", oErrCount, 255);
        frame(0, V - 1, -1, 0);
        check("locked_before_midframe_reset", oLocked, 1);

        // Reset in the middle of a frame, then relock from scratch.
        frame(0, 2, -1, 0);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        checkAllZero("midframe_reset");
        Reset = 1'b0;
        modelReset();
        frame(3, V - 1, -1, 0);
        check("unlocked_rest_of_frame", oLocked, 0);
        frame(0, V - 1, -1, 0);
        check("unlocked_first_frame_after_reset", oLocked, 0);
        frame(0, V - 1, -1, 0);
        check("relocked_after_reset", oLocked, 1);
        check("errcount_after_reset", oErrCount, 0);

        repeat (4) @(posedge Clock);
        #1;
        check("frame_queue_drained", frameQ.size(), 0);
        check("probe_queue_drained", probeQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
